// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line, CLOCKS_POR_BIT clocks per bit.
// Delivers each good byte with a one-cycle byteValido strobe and flags a low stop bit with erroDeQuadro.
module uart_rx #(
   parameter int CLOCKS_POR_BIT = 5209
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       bitSerialEntrada,
   output logic [7:0] byteRecebido,
   output logic       byteValido,
   output logic       erroDeQuadro,
   output logic       indicaRecepcao
);

   localparam int LARGURA = $clog2(CLOCKS_POR_BIT);
   localparam logic [LARGURA-1:0] MEIO_BIT = LARGURA'((CLOCKS_POR_BIT - 1) / 2);
   localparam logic [LARGURA-1:0] FIM_BIT  = LARGURA'(CLOCKS_POR_BIT - 1);

   typedef enum logic [2:0] {
      ESPERA          = 3'd0,
      VERIFICA_INICIO = 3'd1,
      RECEBE_BITS     = 3'd2,
      RECEBE_PARADA   = 3'd3,
      LIMPEZA         = 3'd4,
      AGUARDA_LINHA   = 3'd5
   } estado_t;

   estado_t            estado;
   logic               linhaMeta;
   logic               linhaSync;
   logic [LARGURA-1:0] contadorDeClock;
   logic [2:0]         indice;
   logic [7:0]         registroDeslocamento;

   // Two-flop synchronizer; both flops reset to the idle (high) level.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         linhaMeta <= 1'b1;
         linhaSync <= 1'b1;
      end else begin
         linhaMeta <= bitSerialEntrada;
         linhaSync <= linhaMeta;
      end
   end

   // Output handshake: byteValido and erroDeQuadro are single-cycle strobes with no
   // back-pressure; the consumer must take byteRecebido in the cycle byteValido is high.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado               <= ESPERA;
         contadorDeClock      <= '0;
         indice               <= 3'd0;
         registroDeslocamento <= 8'h00;
         byteRecebido         <= 8'h00;
         byteValido           <= 1'b0;
         erroDeQuadro         <= 1'b0;
         indicaRecepcao       <= 1'b0;
      end else begin
         byteValido   <= 1'b0;
         erroDeQuadro <= 1'b0;
         case (estado)
            ESPERA: begin
               contadorDeClock <= '0;
               indice          <= 3'd0;
               indicaRecepcao  <= 1'b0;
               if (!linhaSync) begin
                  estado         <= VERIFICA_INICIO;
                  indicaRecepcao <= 1'b1;
               end
            end

            // A low that is gone by mid start bit is a glitch, not a frame.
            VERIFICA_INICIO: begin
               if (contadorDeClock == MEIO_BIT) begin
                  contadorDeClock <= '0;
                  if (!linhaSync) begin
                     estado <= RECEBE_BITS;
                  end else begin
                     estado         <= ESPERA;
                     indicaRecepcao <= 1'b0;
                  end
               end else begin
                  contadorDeClock <= contadorDeClock + 1'b1;
               end
            end

            RECEBE_BITS: begin
               if (contadorDeClock == FIM_BIT) begin
                  contadorDeClock              <= '0;
                  registroDeslocamento[indice] <= linhaSync;
                  if (indice == 3'd7) begin
                     indice <= 3'd0;
                     estado <= RECEBE_PARADA;
                  end else begin
                     indice <= indice + 3'd1;
                  end
               end else begin
                  contadorDeClock <= contadorDeClock + 1'b1;
               end
            end

            RECEBE_PARADA: begin
               if (contadorDeClock == FIM_BIT) begin
                  contadorDeClock <= '0;
                  if (linhaSync) begin
                     byteRecebido <= registroDeslocamento;
                     byteValido   <= 1'b1;
                     estado       <= LIMPEZA;
                  end else begin
                     erroDeQuadro <= 1'b1;
                     estado       <= AGUARDA_LINHA;
                  end
               end else begin
                  contadorDeClock <= contadorDeClock + 1'b1;
               end
            end

            LIMPEZA: begin
               estado         <= ESPERA;
               indicaRecepcao <= 1'b0;
            end

            // Hold here through a break so a stuck-low line cannot start a new frame.
            AGUARDA_LINHA: begin
               if (linhaSync) begin
                  estado         <= ESPERA;
                  indicaRecepcao <= 1'b0;
               end
            end

            default: begin
               estado          <= ESPERA;
               contadorDeClock <= '0;
               indice          <= 3'd0;
               indicaRecepcao  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are generated bit by bit at the pin
// and every strobe is scored against the queue of bytes that were sent.
module tb_uart_rx;

   localparam int C = 16;

   logic       clock;
   logic       reset_n;
   logic       bitSerialEntrada;
   logic [7:0] byteRecebido;
   logic       byteValido;
   logic       erroDeQuadro;
   logic       indicaRecepcao;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [7:0] exp_q[$];
   int         expErros   = 0;
   logic [7:0] ultimoByte = 8'h00;
   int         nValidos   = 0;
   int         nErros     = 0;
   logic       indicaVisto = 1'b0;

   uart_rx #(.CLOCKS_POR_BIT(C)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .bitSerialEntrada (bitSerialEntrada),
      .byteRecebido     (byteRecebido),
      .byteValido       (byteValido),
      .erroDeQuadro     (erroDeQuadro),
      .indicaRecepcao   (indicaRecepcao)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
      testsRun++;
      if (obtido !== esperado) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obtido, esperado, $time);
      end
   endtask

   // Scoreboard: every strobe must match something the driver announced.
   always @(negedge clock) begin
      if (reset_n) begin
         if (indicaRecepcao) indicaVisto = 1'b1;
         if (byteValido && erroDeQuadro) verifica("strobes_exclusivos", 1, 0);
         if (byteValido) begin
            nValidos++;
            if (exp_q.size() == 0) begin
               verifica("valido_inesperado", 1, 0);
            end else begin
               logic [7:0] esperado;
               esperado = exp_q.pop_front();
               verifica("byte_recebido", byteRecebido, esperado);
               ultimoByte = esperado;
            end
         end
         if (erroDeQuadro) begin
            nErros++;
            verifica("erro_esperado", (expErros > 0), 1);
            if (expErros > 0) expErros--;
            verifica("byte_mantido_no_erro", byteRecebido, ultimoByte);
         end
      end
   end

   task automatic ciclos(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic envia_quadro(input logic [7:0] dado, input logic bitParada);
      logic [9:0] bits;
      bits = {bitParada, dado, 1'b0};
      if (bitParada) exp_q.push_back(dado);
      else expErros++;
      for (int i = 0; i < 10; i++) begin
         bitSerialEntrada = bits[i];
         ciclos(C);
      end
   endtask

   task automatic verifica_contagem(input string tag, input int v0, input int e0, input int dv, input int de);
      verifica({tag, "_validos"}, nValidos - v0, dv);
      verifica({tag, "_erros"}, nErros - e0, de);
   endtask

   initial begin
      int v0, e0;
      logic [7:0] dado;
      logic [9:0] bits;

      reset_n = 1'b0;
      bitSerialEntrada = 1'b1;
      ciclos(3);
      reset_n = 1'b1;
      verifica("reset_byte", byteRecebido, 8'h00);
      verifica("reset_valido", byteValido, 0);
      verifica("reset_erro", erroDeQuadro, 0);
      verifica("reset_indica", indicaRecepcao, 0);
      indicaVisto = 1'b0;
      ciclos(100);
      verifica("ocioso_indica", indicaVisto, 0);

      // Single frame.
      v0 = nValidos; e0 = nErros; indicaVisto = 1'b0;
      envia_quadro(8'hA5, 1'b1);
      verifica("a5_indica_alto", indicaVisto, 1);
      ciclos(2 * C);
      verifica("a5_indica_baixo", indicaRecepcao, 0);
      verifica_contagem("a5", v0, e0, 1, 0);

      // Back-to-back frames with no idle gap.
      v0 = nValidos; e0 = nErros;
      envia_quadro(8'h00, 1'b1);
      envia_quadro(8'hFF, 1'b1);
      ciclos(2 * C);
      verifica_contagem("seguidos", v0, e0, 2, 0);

      // Short low glitch must be rejected.
      v0 = nValidos; e0 = nErros;
      bitSerialEntrada = 1'b0;
      ciclos(5);
      bitSerialEntrada = 1'b1;
      ciclos(15);
      verifica("glitch_indica", indicaRecepcao, 0);
      verifica_contagem("glitch", v0, e0, 0, 0);
      ciclos(C);
      envia_quadro(8'h3C, 1'b1);
      ciclos(2 * C);
      verifica_contagem("pos_glitch", v0, e0, 1, 0);

      // Framing error followed by a held-low line.
      v0 = nValidos; e0 = nErros;
      envia_quadro(8'h55, 1'b0);
      bitSerialEntrada = 1'b0;
      ciclos(40);
      verifica("quebra_indica", indicaRecepcao, 1);
      verifica_contagem("quebra", v0, e0, 0, 1);
      bitSerialEntrada = 1'b1;
      ciclos(6);
      verifica("quebra_liberada", indicaRecepcao, 0);
      envia_quadro(8'h81, 1'b1);
      ciclos(2 * C);
      verifica_contagem("pos_quebra", v0, e0, 1, 1);

      // Reset in the middle of data bit 4.
      v0 = nValidos; e0 = nErros;
      dado = 8'hC3;
      bits = {1'b1, dado, 1'b0};
      for (int i = 0; i < 5; i++) begin
         bitSerialEntrada = bits[i];
         ciclos(C);
      end
      bitSerialEntrada = bits[5];
      ciclos(C / 2);
      reset_n = 1'b0;
      ciclos(1);
      verifica("abort_byte", byteRecebido, 8'h00);
      verifica("abort_valido", byteValido, 0);
      verifica("abort_erro", erroDeQuadro, 0);
      verifica("abort_indica", indicaRecepcao, 0);
      ultimoByte = 8'h00;
      bitSerialEntrada = 1'b1;
      ciclos(2);
      reset_n = 1'b1;
      ciclos(C);
      envia_quadro(8'h7E, 1'b1);
      ciclos(2 * C);
      verifica_contagem("pos_abort", v0, e0, 1, 0);

      // Random traffic, occasionally with a bad stop bit.
      for (int n = 0; n < 24; n++) begin
         logic bom;
         bom = ($urandom_range(0, 4) != 0);
         envia_quadro(8'($urandom_range(0, 255)), bom);
         bitSerialEntrada = 1'b1;
         ciclos(bom ? $urandom_range(0, 20) : $urandom_range(4, 20));
      end

      ciclos(3 * C);
      verifica("fila_vazia", exp_q.size(), 0);
      verifica("erros_pendentes", expErros, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
